// File: rtl/pulse_dly_bank.sv
// pulse_dly_bank: bank of NCH runtime-programmable one-shot pulse delay lines
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   trig     in   per-channel trigger, one trigger per high edge
//   ld       in   delay register load strobe
//   ld_ch    in   channel addressed by ld (values >= NCH ignored)
//   ld_val   in   new delay in ticks
//   ovr_clr  in   per-channel clear of the sticky overrun flag
//   p        out  per-channel delayed one-cycle pulse
//   busy     out  per-channel counting status
//   ovr      out  per-channel sticky dropped-trigger flag
module pulse_dly_bank #(
    parameter int NCH = 4,
    parameter int CW = 16,
    parameter int CHW = 2,
    parameter int CLK_NS = 20,
    parameter int DEF_DLY = 50,
    parameter logic [NCH-1:0] RETRIG = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] trig,
    input  logic           ld,
    input  logic [CHW-1:0] ld_ch,
    input  logic [CW-1:0]  ld_val,
    input  logic [NCH-1:0] ovr_clr,
    output logic [NCH-1:0] p,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] ovr
);
    if (NCH < 1 || NCH > 16 || CHW < 1 || CHW < $clog2(NCH) || CLK_NS < 1) begin : g_bad
        $error("pulse_dly_bank: illegal parameters");
    end
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] dly, cnt;
        logic p_r, busy_r, ovr_r;
        logic en, fire, acc, drop;
        // the firing edge both emits the old pulse and may accept a new trigger
        always_comb begin
            en = trig[i] && dly != '0;
            fire = busy_r && cnt == CW'(1);
            acc = en && (!busy_r || fire || RETRIG[i]);
            drop = en && busy_r && !fire && !RETRIG[i];
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                dly <= CW'(DEF_DLY);
                cnt <= '0;
                busy_r <= 1'b0;
                p_r <= 1'b0;
                ovr_r <= 1'b0;
            end else begin
                if (ld && 32'(ld_ch) == i) dly <= ld_val;
                cnt <= acc ? dly : fire ? '0 : busy_r ? cnt - CW'(1) : cnt;
                busy_r <= acc || (busy_r && !fire);
                p_r <= fire;
                ovr_r <= drop || (ovr_r && !ovr_clr[i]);
            end
        end
        assign p[i] = p_r;
        assign busy[i] = busy_r;
        assign ovr[i] = ovr_r;
    end
endmodule

// File: tb/tb_pulse_dly_bank.sv
// tb_pulse_dly_bank: scoreboard bench with a deadline-based reference model
module tb_pulse_dly_bank;
    localparam int NCH = 4;
    localparam int CW = 16;
    localparam int CHW = 2;
    localparam logic [NCH-1:0] RT = 4'b0100;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NCH-1:0] trig = '0;
    logic ld = 1'b0;
    logic [CHW-1:0] ld_ch = '0;
    logic [CW-1:0] ld_val = '0;
    logic [NCH-1:0] ovr_clr = '0;
    logic [NCH-1:0] p, busy, ovr;
    typedef struct packed {
        logic [NCH-1:0] p;
        logic [NCH-1:0] b;
        logic [NCH-1:0] o;
    } exp_t;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    longint n = 0;
    longint dl[NCH];
    int dm[NCH];
    logic [NCH-1:0] om;
    pulse_dly_bank #(.NCH(NCH), .CW(CW), .CHW(CHW), .CLK_NS(20), .DEF_DLY(50), .RETRIG(RT)) dut (
        .clk(clk), .reset(reset), .trig(trig), .ld(ld), .ld_ch(ld_ch), .ld_val(ld_val),
        .ovr_clr(ovr_clr), .p(p), .busy(busy), .ovr(ovr)
    );
    always #10 clk = ~clk;
    // each channel holds the absolute edge number at which its pulse is due
    task automatic model();
        exp_t e;
        e = '0;
        n++;
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                dl[i] = -1;
                dm[i] = 50;
                om[i] = 1'b0;
            end else begin
                bit fire, pend, en;
                fire = dl[i] == n;
                pend = dl[i] > n;
                en = trig[i] && dm[i] != 0;
                e.p[i] = fire;
                if (en && (!pend || RT[i])) dl[i] = n + dm[i];
                if (en && pend && !RT[i]) om[i] = 1'b1;
                else if (ovr_clr[i]) om[i] = 1'b0;
                e.b[i] = dl[i] > n;
            end
        end
        e.o = om;
        if (!reset && ld && int'(ld_ch) < NCH) dm[ld_ch] = int'(ld_val);
        q.push_back(e);
    endtask
    task automatic tick();
        @(posedge clk);
        model();
        @(negedge clk);
        reset = 1'b0;
        trig = '0;
        ld = 1'b0;
        ovr_clr = '0;
    endtask
    task automatic idle(input int k);
        for (int j = 0; j < k; j++) tick();
    endtask
    task automatic load(input int ch, input int v);
        ld = 1'b1;
        ld_ch = CHW'(ch);
        ld_val = CW'(v);
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 3;
            if (p !== e.p) begin
                errors++;
                $display("FAIL p @%0t: got %b want %b", $time, p, e.p);
            end
            if (busy !== e.b) begin
                errors++;
                $display("FAIL busy @%0t: got %b want %b", $time, busy, e.b);
            end
            if (ovr !== e.o) begin
                errors++;
                $display("FAIL ovr @%0t: got %b want %b", $time, ovr, e.o);
            end
        end
    end
    initial begin
        reset = 1'b1;
        tick();
        trig = 4'b0001;
        tick();
        idle(55);
        load(1, 3);
        tick();
        trig = 4'b0010;
        tick();
        trig = 4'b0010;
        tick();
        idle(5);
        ovr_clr = 4'b0010;
        tick();
        idle(2);
        load(2, 5);
        tick();
        trig = 4'b0100;
        tick();
        idle(2);
        trig = 4'b0100;
        tick();
        idle(10);
        load(3, 4);
        tick();
        trig = 4'b1000;
        tick();
        idle(3);
        trig = 4'b1000;
        tick();
        idle(8);
        load(0, 0);
        tick();
        trig = 4'b0001;
        tick();
        idle(3);
        load(0, 1);
        trig = 4'b0001;
        tick();
        idle(3);
        trig = 4'b0001;
        tick();
        idle(3);
        trig = 4'b1111;
        tick();
        idle(9);
        reset = 1'b1;
        tick();
        idle(100);
        trig = 4'b1111;
        tick();
        idle(55);
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NCH; i++) begin
                trig[i] = $urandom_range(0, 7) == 0;
                ovr_clr[i] = $urandom_range(0, 15) == 0;
            end
            if ($urandom_range(0, 9) == 0) load(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 12)));
            reset = $urandom_range(0, 499) == 0;
            tick();
        end
        idle(2);
        for (int j = 0; j < 5 && q.size() > 0; j++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
